// File: rtl/awg_key_ctrl.sv
// Front-panel key conditioning for the sawtooth generator: debounce, auto-repeat,
// field-select FSM and the registered en/freq/amp/phase values.
module awg_key_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 25_000_000,
    parameter int unsigned REPEAT_CYCLES   = 5_000_000,
    parameter int unsigned FREQ_STEP       = 16,
    parameter int unsigned FREQ_RST        = 64,
    parameter int unsigned PHASE_STEP      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_n,
    output logic        en,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic [1:0]  field_sel,
    output logic        upd
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    typedef enum logic [1:0] {
        FLD_FREQ  = 2'd0,
        FLD_AMP   = 2'd1,
        FLD_PHASE = 2'd2
    } field_t;

    // Internally 1 = pressed.
    logic [3:0]    sync1, sync2, deb, deb_d, armed;
    logic [1:0]    sync_vld;
    logic [DW-1:0] deb_cnt [4];
    logic [3:0]    press;

    logic [HW-1:0] hold_cnt [2];
    logic [1:0]    rpt_mode, rep_raw;
    logic          ev_up, ev_dn, step_up, step_dn;

    field_t        field_q, field_nxt;
    logic          en_nxt, changed;
    logic [11:0]   freq_nxt;
    logic [2:0]    amp_nxt;
    logic [7:0]    phase_nxt;

    // A key only arms once a real post-reset sample shows it released, so a key
    // held through reset cannot produce an event at reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_d    <= '0;
            armed    <= '0;
            sync_vld <= '0;
            for (int unsigned k = 0; k < 4; k++) deb_cnt[k] <= '0;
        end else begin
            sync1    <= ~key_n;
            sync2    <= sync1;
            deb_d    <= deb;
            sync_vld <= {sync_vld[0], 1'b1};
            for (int unsigned k = 0; k < 4; k++) begin
                armed[k] <= armed[k] | (sync_vld[1] & ~sync2[k]);
                if (sync2[k] != deb[k]) begin
                    if (deb_cnt[k] == DW'(DEBOUNCE_CYCLES)) begin
                        deb[k]     <= sync2[k];
                        deb_cnt[k] <= '0;
                    end else begin
                        deb_cnt[k] <= deb_cnt[k] + DW'(1);
                    end
                end else begin
                    deb_cnt[k] <= '0;
                end
            end
        end
    end

    assign press = deb & ~deb_d & armed;

    // hold_cnt[u] serves key u+1 (up/down); it starts at the press pulse and reloads on each repeat.
    always_comb begin
        for (int unsigned u = 0; u < 2; u++)
            rep_raw[u] = (hold_cnt[u] == (rpt_mode[u] ? HW'(REPEAT_CYCLES) : HW'(HOLD_CYCLES)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_mode <= '0;
            for (int unsigned u = 0; u < 2; u++) hold_cnt[u] <= '0;
        end else begin
            for (int unsigned u = 0; u < 2; u++) begin
                if (!deb[u+1]) begin
                    hold_cnt[u] <= '0;
                    rpt_mode[u] <= 1'b0;
                end else if (press[u+1]) begin
                    hold_cnt[u] <= HW'(1);
                    rpt_mode[u] <= 1'b0;
                end else if (rep_raw[u]) begin
                    hold_cnt[u] <= HW'(1);
                    rpt_mode[u] <= 1'b1;
                end else if (hold_cnt[u] != '0) begin
                    hold_cnt[u] <= hold_cnt[u] + HW'(1);
                end
            end
        end
    end

    assign ev_up   = press[1] | (rep_raw[0] & ~deb[2]);
    assign ev_dn   = press[2] | (rep_raw[1] & ~deb[1]);
    assign step_up = ev_up & ~ev_dn & ~press[0];
    assign step_dn = ev_dn & ~ev_up & ~press[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) field_q <= FLD_FREQ;
        else        field_q <= field_nxt;
    end

    always_comb begin
        field_nxt = field_q;
        if (press[0]) begin
            case (field_q)
                FLD_FREQ: field_nxt = FLD_AMP;
                FLD_AMP:  field_nxt = FLD_PHASE;
                default:  field_nxt = FLD_FREQ;
            endcase
        end
    end

    assign field_sel = field_q;

    always_comb begin
        en_nxt    = en ^ press[3];
        freq_nxt  = state_freq;
        amp_nxt   = state_amp;
        phase_nxt = state_phase;
        if (step_up || step_dn) begin
            case (field_q)
                FLD_FREQ: begin
                    if (step_up)
                        freq_nxt = (state_freq > 12'(4095 - FREQ_STEP)) ? 12'd4095 : state_freq + 12'(FREQ_STEP);
                    else
                        freq_nxt = (state_freq <= 12'(FREQ_STEP)) ? 12'd1 : state_freq - 12'(FREQ_STEP);
                end
                FLD_AMP: begin
                    if (step_up) amp_nxt = (state_amp > 3'd1) ? state_amp - 3'd1 : 3'd1;
                    else         amp_nxt = (state_amp < 3'd7) ? state_amp + 3'd1 : 3'd7;
                end
                FLD_PHASE: begin
                    if (step_up) phase_nxt = state_phase + 8'(PHASE_STEP);
                    else         phase_nxt = state_phase - 8'(PHASE_STEP);
                end
                default: ;
            endcase
        end
        changed = (en_nxt != en) || (freq_nxt != state_freq) ||
                  (amp_nxt != state_amp) || (phase_nxt != state_phase);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en          <= 1'b0;
            state_freq  <= 12'(FREQ_RST);
            state_amp   <= 3'd1;
            state_phase <= '0;
            upd         <= 1'b0;
        end else begin
            en          <= en_nxt;
            state_freq  <= freq_nxt;
            state_amp   <= amp_nxt;
            state_phase <= phase_nxt;
            upd         <= changed;
        end
    end

endmodule

// File: tb/tb_awg_key_ctrl.sv
// Scoreboard bench for awg_key_ctrl: stimulus pushes expected (cycle, values) on each
// update, a negedge monitor pops and compares whenever upd is seen.
module tb_awg_key_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key_n;
    logic        en;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic [1:0]  field_sel;
    logic        upd;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int at;
        int e;
        int f;
        int a;
        int p;
    } exp_t;
    exp_t sb[$];

    awg_key_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(20),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_n(key_n),
        .en(en),
        .state_freq(state_freq),
        .state_amp(state_amp),
        .state_phase(state_phase),
        .field_sel(field_sel),
        .upd(upd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int at, input int e, input int f, input int a, input int p);
        exp_t x;
        x.at = at; x.e = e; x.f = f; x.a = a; x.p = p;
        sb.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask, input int hold, input int gap);
        key_n = key_n & ~mask;
        tick(hold);
        key_n = key_n | mask;
        tick(gap);
    endtask

    // Monitor: every upd pulse must match the oldest expected update, including its cycle.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n === 1'b1 && upd === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_upd: cyc %0d en=%0d f=%0d a=%0d p=%0d, required no upd",
                         cyc, en, state_freq, state_amp, state_phase);
            end else begin
                x = sb.pop_front();
                if (x.at != cyc || x.e != int'(en) || x.f != int'(state_freq) ||
                    x.a != int'(state_amp) || x.p != int'(state_phase)) begin
                    errors++;
                    $display("FAIL upd_value: got cyc %0d en=%0d f=%0d a=%0d p=%0d, required cyc %0d en=%0d f=%0d a=%0d p=%0d",
                             cyc, en, state_freq, state_amp, state_phase, x.at, x.e, x.f, x.a, x.p);
                end
            end
        end
    end

    initial begin
        int c;
        key_n = '1;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // Reset values
        check("rst_en", int'(en), 0);
        check("rst_freq", int'(state_freq), 64);
        check("rst_amp", int'(state_amp), 1);
        check("rst_phase", int'(state_phase), 0);
        check("rst_field", int'(field_sel), 0);
        check("rst_upd", int'(upd), 0);

        // Clean press: update 7 edges after first low sample
        c = cyc;
        push(c + 8, 0, 80, 1, 0);
        press(4'b0010, 10, 20);
        check("press_drained", sb.size(), 0);

        // Bounce: 3-cycle glitches are rejected
        for (int i = 0; i < 5; i++) begin
            key_n[1] = 1'b0; tick(3);
            key_n[1] = 1'b1; tick(3);
        end
        tick(20);
        check("bounce_freq", int'(state_freq), 80);

        // AMP saturation
        press(4'b0001, 8, 12);
        check("field_amp", int'(field_sel), 1);
        press(4'b0010, 8, 12);
        check("amp_sat_hi", int'(state_amp), 1);
        for (int i = 0; i < 8; i++) begin
            c = cyc;
            if (i < 6) push(c + 8, 0, 80, 2 + i, 0);
            press(4'b0100, 8, 12);
        end
        check("amp_sat_lo", int'(state_amp), 7);
        check("amp_drained", sb.size(), 0);

        // PHASE wrap and auto-repeat
        press(4'b0001, 8, 12);
        check("field_phase", int'(field_sel), 2);
        c = cyc;
        push(c + 8, 0, 80, 7, 248);
        push(c + 28, 0, 80, 7, 240);
        push(c + 36, 0, 80, 7, 232);
        push(c + 44, 0, 80, 7, 224);
        push(c + 52, 0, 80, 7, 216);
        push(c + 60, 0, 80, 7, 208);
        push(c + 68, 0, 80, 7, 200);
        press(4'b0100, 66, 20);
        check("phase_drained", sb.size(), 0);
        check("phase_final", int'(state_phase), 200);

        // FREQ saturation via auto-repeat up to 4095
        press(4'b0001, 8, 12);
        check("field_freq", int'(field_sel), 0);
        c = cyc;
        push(c + 8, 0, 96, 7, 200);
        for (int n = 2; n <= 251; n++)
            push(c + 28 + 8 * (n - 2), 0, (80 + 16 * n > 4095) ? 4095 : 80 + 16 * n, 7, 200);
        press(4'b0010, 2046, 20);
        check("freq_sat", int'(state_freq), 4095);
        check("freq_drained", sb.size(), 0);
        press(4'b0010, 8, 12);
        check("freq_sat_again", int'(state_freq), 4095);

        // Simultaneous events
        press(4'b0110, 8, 12);
        check("updn_freq", int'(state_freq), 4095);
        press(4'b0011, 8, 12);
        check("mode_up_field", int'(field_sel), 1);
        check("mode_up_amp", int'(state_amp), 7);
        c = cyc;
        push(c + 8, 1, 4095, 6, 200);
        press(4'b1010, 8, 12);
        check("en_up_drained", sb.size(), 0);

        // Reset mid-hold
        c = cyc;
        push(c + 8, 1, 4095, 5, 200);
        key_n[1] = 1'b0;
        tick(12);
        rst_n = 1'b0;
        #1;
        check("async_en", int'(en), 0);
        check("async_freq", int'(state_freq), 64);
        check("async_amp", int'(state_amp), 1);
        check("async_phase", int'(state_phase), 200 - 200);
        check("async_field", int'(field_sel), 0);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        check("held_no_event", int'(state_freq), 64);
        key_n[1] = 1'b1;
        tick(15);
        c = cyc;
        push(c + 8, 0, 80, 1, 0);
        press(4'b0010, 8, 12);
        tick(10);
        check("final_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
